// File: rtl/tile_draw_arbiter.sv
// tile_draw_arbiter: shares the tile-painting datapath between sequence
// playback (requester 0) and player-input feedback (requester 1).
// One whole-tile command is accepted at a time. The arbiter then sequences
// the load, the PIXELS-long write burst, the done pulse and an optional gap.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on a tie;
// otherwise requester 0 always wins a tie.
//
// state | meaning
// IDLE  | waiting for req0/req1; the winner is latched on leaving
// LOAD  | ack to the winner, datapath loads tile coordinates and colour
// DRAW  | PIXELS write cycles, pix_idx counts 0..PIXELS-1
// DONE  | done pulse to the winner
// GAP   | GAP_CYCLES idle cycles before the next grant
module tile_draw_arbiter #(
  parameter int TILE_SIZE  = 8,
  parameter int PIX_W      = 6,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       tile0,
  input  logic             flash0,
  input  logic             req1,
  input  logic [1:0]       tile1,
  input  logic             flash1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic             ld_tile,
  output logic             ld_flash,
  output logic [1:0]       tile_num,
  output logic             writeEnable,
  output logic             counterEnable,
  output logic [PIX_W-1:0] pix_idx,
  output logic             busy
);

  localparam int PIXELS = TILE_SIZE * TILE_SIZE;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  // The gap timer counts down to zero, so it is loaded with one less than the gap length.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] DRAW = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       grant;
  logic       last_grant;
  logic       flash_q;
  logic       win;
  logic [3:0] gap_cnt;

  // Pick the winner; on a tie, round-robin favours whoever did not win last time.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = RR_EN & ~last_grant;
    else if (req1)    win = 1'b1;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req0 || req1) state_nx = LOAD;
      LOAD: state_nx = DRAW;
      DRAW: if (pix_idx == PIX_LAST) state_nx = DONE;
      DONE: state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:  if (gap_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, grant capture, pixel counter and gap timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tile_num   <= 2'd0;
      flash_q    <= 1'b0;
      pix_idx    <= '0;
      gap_cnt    <= 4'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= win;
            last_grant <= win;
            tile_num   <= win ? tile1 : tile0;
            flash_q    <= win ? flash1 : flash0;
          end
        end
        DRAW: pix_idx <= (pix_idx == PIX_LAST) ? '0 : pix_idx + 1'b1;
        DONE: gap_cnt <= GAP_LOAD;
        GAP:  if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign ack0          = (state == LOAD) && !grant;
  assign ack1          = (state == LOAD) &&  grant;
  assign done0         = (state == DONE) && !grant;
  assign done1         = (state == DONE) &&  grant;
  assign ld_tile       = (state == LOAD);
  assign ld_flash      = (state == LOAD) && flash_q;
  assign writeEnable   = (state == DRAW);
  assign counterEnable = (state == DRAW);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Bench for tile_draw_arbiter: transaction-level model (offset from the grant
// edge) checked every cycle, plus literal latency/order pins and random traffic.
module tb_tile_draw_arbiter;
  localparam int TILE_SIZE = 8;
  localparam int PIX_W     = 6;
  localparam int GAP       = 1;
  localparam int PIXELS    = TILE_SIZE * TILE_SIZE;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock, reset;
  logic req0, flash0, req1, flash1;
  logic [1:0] tile0, tile1, tile_num;
  logic ack0, ack1, done0, done1, ld_tile, ld_flash, writeEnable, counterEnable, busy;
  logic [PIX_W-1:0] pix_idx;

  tile_draw_arbiter #(.TILE_SIZE(TILE_SIZE), .PIX_W(PIX_W), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .tile0(tile0), .flash0(flash0),
    .req1(req1), .tile1(tile1), .flash1(flash1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .ld_tile(ld_tile), .ld_flash(ld_flash), .tile_num(tile_num),
    .writeEnable(writeEnable), .counterEnable(counterEnable),
    .pix_idx(pix_idx), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: a burst is described only by its offset from the grant edge.
  bit       m_active = 1'b0;
  int       m_off = 0;
  bit       m_who = 1'b0;
  bit       m_last = 1'b1;
  bit       m_flash = 1'b0;
  logic [1:0] m_tile = 2'd0;

  int n_ack0, n_ack1, n_done0, n_done1, n_we;
  int ack_cyc[$];
  bit ack_who[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0; m_off = 0; m_last = 1'b1; m_who = 1'b0; m_tile = 2'd0; m_flash = 1'b0;
    end else if (m_active) begin
      m_off++;
      if (m_off == 67 + GAP) begin m_active = 1'b0; m_off = 0; end
    end else if (req0 || req1) begin
      if (req0 && req1) m_who = RR ? !m_last : 1'b0;
      else m_who = req1;
      m_last   = m_who;
      m_tile   = m_who ? tile1 : tile0;
      m_flash  = m_who ? flash1 : flash0;
      m_active = 1'b1;
      m_off    = 1;
    end
  end

  always @(negedge clock) begin
    bit e_load, e_draw, e_done;
    if (chk_en) begin
      e_load = m_active && m_off == 1;
      e_draw = m_active && m_off >= 2 && m_off <= PIXELS + 1;
      e_done = m_active && m_off == PIXELS + 2;
      chk("ack0", ack0, e_load && !m_who);
      chk("ack1", ack1, e_load && m_who);
      chk("done0", done0, e_done && !m_who);
      chk("done1", done1, e_done && m_who);
      chk("ld_tile", ld_tile, e_load);
      chk("ld_flash", ld_flash, e_load && m_flash);
      chk("tile_num", tile_num, m_tile);
      chk("writeEnable", writeEnable, e_draw);
      chk("counterEnable", counterEnable, e_draw);
      chk("pix_idx", pix_idx, e_draw ? m_off - 2 : 0);
      chk("busy", busy, m_active);
      if (ack0 || ack1) begin ack_cyc.push_back(cyc); ack_who.push_back(ack1); end
      n_ack0 += int'(ack0); n_ack1 += int'(ack1);
      n_done0 += int'(done0); n_done1 += int'(done1);
      n_we += int'(writeEnable);
    end
  end

  task automatic clear_counts();
    n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0; n_we = 0;
    ack_cyc.delete(); ack_who.delete();
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the ack cycle with req dropped.
  task automatic request(input bit who, input logic [1:0] t, input bit f);
    int n = 0;
    bit got = 1'b0;
    if (who) begin req1 = 1'b1; tile1 = t; flash1 = f; end
    else     begin req0 = 1'b1; tile0 = t; flash0 = f; end
    while (!got && n < 3000) begin
      @(negedge clock);
      n++;
      got = who ? ack1 : ack0;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout who=%0d got=none exp=ack", who);
    end
    @(posedge clock); #1;
    if (who) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_idle(output int when);
    int n = 0;
    when = -1;
    while (n < 500) begin
      @(negedge clock);
      n++;
      if (!busy) begin when = cyc; break; end
    end
    if (when < 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout got=busy exp=idle");
    end
    @(posedge clock); #1;
  endtask

  task automatic master(input bit who, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clock);
      #1;
      request(who, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        if (who) begin tile1 = 2'($urandom); flash1 = 1'($urandom); end
        else     begin tile0 = 2'($urandom); flash0 = 1'($urandom); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, tw, n, other;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tile0 = 2'd0; tile1 = 2'd0; flash0 = 1'b0; flash1 = 1'b0;
    @(posedge clock); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_tile_num", tile_num, 0);
    @(posedge clock); #1;

    // Single request 0: latency pins.
    clear_counts();
    t0 = cyc;
    request(1'b0, 2'd2, 1'b1);
    wait_idle(tw);
    chk("t1_ack_lat", (ack_cyc.size() > 0) ? ack_cyc[0] - t0 : -1, 1);
    chk("t1_idle_lat", tw - t0, 68);
    chk("t1_writes", n_we, 64);
    chk("t1_done0", n_done0, 1);

    // Single request 1: no requester-0 activity.
    clear_counts();
    request(1'b1, 2'd3, 1'b0);
    wait_idle(tw);
    chk("t2_ack1", n_ack1, 1);
    chk("t2_ack0", n_ack0, 0);
    chk("t2_done1", n_done1, 1);
    chk("t2_done0", n_done0, 0);
    chk("t2_writes", n_we, 64);

    // Tile changes after the grant must not reach the current burst.
    request(1'b0, 2'd1, 1'b0);
    @(posedge clock); #1 tile0 = 2'd0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("t3_tile_held", tile_num, 1);
    wait_idle(tw);

    // Reset in the middle of the burst: no done, then a full fresh burst.
    clear_counts();
    request(1'b0, 2'd2, 1'b1);
    n = 0;
    while (pix_idx != 6'd20 && n < 200) begin @(posedge clock); #1; n++; end
    chk("t4_reached_pix20", pix_idx, 20);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t4_busy_after_rst", busy, 0);
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    chk("t4_no_done", n_done0, 0);
    clear_counts();
    request(1'b0, 2'd3, 1'b0);
    wait_idle(tw);
    chk("t4_full_burst", n_we, 64);
    chk("t4_done_after", n_done0, 1);

    // Both requesters held continuously.
    clear_counts();
    req0 = 1'b1; tile0 = 2'd1; flash0 = 1'b0;
    req1 = 1'b1; tile1 = 2'd2; flash1 = 1'b1;
    n = 0;
    while (ack_cyc.size() < 4 && n < 1000) begin @(negedge clock); n++; end
    if (ack_cyc.size() < 4) begin
      checks++; errors++;
      $display("FAIL tie_timeout got=%0d acks exp=4", ack_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("tie_order", ack_who[i], RR ? (i % 2) : 0);
        if (i > 0) chk("tie_spacing", ack_cyc[i] - ack_cyc[i-1], 67 + GAP);
      end
    end
    @(posedge clock); #1;
    if (ack_who.size() > 0 && ack_who[ack_who.size()-1]) req1 = 1'b0; else req0 = 1'b0;
    other = req1 ? 1 : 0;
    n = 0;
    while (n < 1000) begin
      @(negedge clock);
      n++;
      if (other == 1 ? ack1 : ack0) break;
    end
    chk("tie_leftover_ack", n < 1000, 1);
    @(posedge clock); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(tw);

    // Random traffic from both requesters.
    fork
      master(1'b0, 12);
      master(1'b1, 12);
    join
    wait_idle(tw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
